// File: rtl/spi_xfer_sched_pkg.sv
// Shared definitions for the SPI transaction scheduler: SPI master register
// bit positions, the forced SPCR bits and the scheduler FSM encoding.
package spi_xfer_sched_pkg;

  localparam int SPCR_SPIE = 7;
  localparam int SPCR_SPE  = 6;
  localparam int SPCR_MSTR = 4;
  localparam int SPSR_SPIF = 7;

  // Interrupt enable, SPI enable and master mode are always set on configure.
  localparam logic [7:0] SPCR_FORCE = (8'd1 << SPCR_SPIE) | (8'd1 << SPCR_SPE) | (8'd1 << SPCR_MSTR);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CFG    = 3'd1,
    ST_SETUP  = 3'd2,
    ST_WRDR   = 3'd3,
    ST_WAITIF = 3'd4,
    ST_RDDR   = 3'd5,
    ST_CLR    = 3'd6,
    ST_HOLD   = 3'd7
  } state_t;

  function automatic logic [7:0] spcr_image(input logic [7:0] cfg);
    return cfg | SPCR_FORCE;
  endfunction

endpackage

// File: rtl/spi_xfer_sched_arbiter.sv
// Combinational round-robin pick: scans requests starting at i_ptr and
// returns the first requester as a one-hot vector and as an index.
module spi_rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler driving the SPI master's IO register bus on behalf
// of NREQ clients: configure, per-byte write/wait/read/clear, chip select framing.
module spi_xfer_sched
  import spi_xfer_sched_pkg::*;
#(
  parameter int NREQ            = 2,
  parameter int BUS_ADDR_IO_LEN = 6,
  parameter int SPCR_ADDR       = 0,
  parameter int SPSR_ADDR       = 1,
  parameter int SPDR_ADDR       = 2,
  parameter int CS_SETUP        = 2,
  parameter int CS_HOLD         = 2,
  parameter int LEN_W           = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*8-1:0]          req_cfg,
  input  logic [NREQ*LEN_W-1:0]      req_len,
  input  logic [NREQ*8-1:0]          tx_data,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            tx_ready,
  output logic [7:0]                 rx_data,
  output logic [NREQ-1:0]            rx_valid,
  output logic [NREQ-1:0]            done,
  output logic [NREQ-1:0]            ss_n,
  output logic                       busy,
  output logic [BUS_ADDR_IO_LEN-1:0] m_addr,
  output logic                       m_wr,
  output logic                       m_rd,
  output logic [7:0]                 m_bus_in,
  input  logic [7:0]                 m_bus_out,
  input  logic                       m_int,
  output logic                       m_int_rst
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [BUS_ADDR_IO_LEN-1:0] A_SPCR = BUS_ADDR_IO_LEN'(SPCR_ADDR);
  localparam logic [BUS_ADDR_IO_LEN-1:0] A_SPSR = BUS_ADDR_IO_LEN'(SPSR_ADDR);
  localparam logic [BUS_ADDR_IO_LEN-1:0] A_SPDR = BUS_ADDR_IO_LEN'(SPDR_ADDR);

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [NREQ-1:0]    r_sel;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_bcnt;
  logic [7:0]         r_tmr;
  logic               r_int;

  logic [NREQ-1:0]    w_win;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [7:0]         w_cfg_win;
  logic [LEN_W-1:0]   w_len_win;
  logic [7:0]         w_tx_sel;

  spi_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_win),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // The client just served drops to lowest priority on the next arbitration.
  assign w_ptr_nxt = (w_idx == IDX_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  always_comb begin
    w_cfg_win = '0;
    w_len_win = '0;
    w_tx_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_cfg_win = req_cfg[i*8 +: 8];
        w_len_win = req_len[i*LEN_W +: LEN_W];
      end
      if (r_sel[i]) w_tx_sel = tx_data[i*8 +: 8];
    end
  end

  assign busy = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_sel     <= '0;
      r_len     <= '0;
      r_bcnt    <= '0;
      r_tmr     <= '0;
      r_int     <= 1'b0;
      gnt       <= '0;
      ss_n      <= '1;
      tx_ready  <= '0;
      rx_valid  <= '0;
      rx_data   <= '0;
      done      <= '0;
      m_addr    <= A_SPSR;
      m_wr      <= 1'b0;
      m_rd      <= 1'b0;
      m_bus_in  <= '0;
      m_int_rst <= 1'b0;
    end else begin
      tx_ready  <= '0;
      rx_valid  <= '0;
      done      <= '0;
      m_wr      <= 1'b0;
      m_rd      <= 1'b0;
      m_int_rst <= 1'b0;
      r_int     <= m_int;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_sel    <= w_win;
            gnt      <= w_win;
            ss_n     <= ~w_win;
            r_len    <= w_len_win;
            r_bcnt   <= '0;
            r_ptr    <= w_ptr_nxt;
            m_wr     <= 1'b1;
            m_addr   <= A_SPCR;
            m_bus_in <= spcr_image(w_cfg_win);
            r_state  <= ST_CFG;
          end
        end
        ST_CFG: begin
          r_tmr   <= 8'(CS_SETUP - 1);
          r_state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (r_tmr == 8'd0) begin
            m_wr     <= 1'b1;
            m_addr   <= A_SPDR;
            m_bus_in <= w_tx_sel;
            tx_ready <= r_sel;
            r_state  <= ST_WRDR;
          end else begin
            r_tmr <= r_tmr - 8'd1;
          end
        end
        ST_WRDR: begin
          r_state <= ST_WAITIF;
        end
        // r_int lags m_int by a cycle; the stale SPIF seen right after CLR
        // lands in WRDR, which ignores it.
        ST_WAITIF: begin
          if (r_int) begin
            m_rd    <= 1'b1;
            m_addr  <= A_SPDR;
            r_state <= ST_RDDR;
          end
        end
        ST_RDDR: begin
          rx_data   <= m_bus_out;
          rx_valid  <= r_sel;
          m_int_rst <= 1'b1;
          r_state   <= ST_CLR;
        end
        // Compare before increment so a full 2^LEN_W burst never wraps.
        ST_CLR: begin
          if (r_bcnt == r_len) begin
            r_tmr   <= 8'(CS_HOLD - 1);
            r_state <= ST_HOLD;
            if (CS_HOLD == 1) begin
              done   <= r_sel;
              ss_n   <= '1;
              gnt    <= '0;
              m_addr <= A_SPSR;
            end
          end else begin
            r_bcnt   <= r_bcnt + 1'b1;
            m_wr     <= 1'b1;
            m_addr   <= A_SPDR;
            m_bus_in <= w_tx_sel;
            tx_ready <= r_sel;
            r_state  <= ST_WRDR;
          end
        end
        ST_HOLD: begin
          if (r_tmr == 8'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_tmr <= r_tmr - 8'd1;
            if (r_tmr == 8'd1) begin
              done   <= r_sel;
              ss_n   <= '1;
              gnt    <= '0;
              m_addr <= A_SPSR;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched with a loopback SPI master model and
// counting client models on both requesters.
module tb_spi_xfer_sched;
  import spi_xfer_sched_pkg::*;

  localparam int NREQ  = 2;
  localparam int LEN_W = 8;
  localparam int AW    = 6;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*8-1:0]     req_cfg = '0;
  logic [NREQ*LEN_W-1:0] req_len = '0;
  logic [NREQ*8-1:0]     tx_data;
  logic [NREQ-1:0]       gnt, tx_ready, rx_valid, done, ss_n;
  logic [7:0]            rx_data;
  logic                  busy;
  logic [AW-1:0]         m_addr;
  logic                  m_wr, m_rd, m_int, m_int_rst;
  logic [7:0]            m_bus_in, m_bus_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_xfer_sched #(
    .NREQ(NREQ), .BUS_ADDR_IO_LEN(AW), .SPCR_ADDR(0), .SPSR_ADDR(1), .SPDR_ADDR(2),
    .CS_SETUP(2), .CS_HOLD(2), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_cfg(req_cfg), .req_len(req_len),
    .tx_data(tx_data), .gnt(gnt), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .done(done), .ss_n(ss_n), .busy(busy), .m_addr(m_addr),
    .m_wr(m_wr), .m_rd(m_rd), .m_bus_in(m_bus_in), .m_bus_out(m_bus_out),
    .m_int(m_int), .m_int_rst(m_int_rst)
  );

  // SPI master model: loopback shift of 4 cycles, then SPIF.
  logic [7:0] mst_spcr, mst_shreg;
  logic       mst_spif;
  int         mst_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_spcr <= '0; mst_shreg <= '0; mst_spif <= 1'b0; mst_cnt <= 0;
    end else begin
      if (m_wr && m_addr == 6'd0) mst_spcr <= m_bus_in;
      if (m_wr && m_addr == 6'd2) begin
        mst_shreg <= m_bus_in;
        mst_cnt   <= 4;
      end else if (mst_cnt != 0) begin
        mst_cnt <= mst_cnt - 1;
        if (mst_cnt == 1) mst_spif <= 1'b1;
      end
      if (m_int_rst) mst_spif <= 1'b0;
    end
  end

  assign m_int = mst_spif & mst_spcr[SPCR_SPIE];

  always_comb begin
    m_bus_out = 8'h00;
    case (m_addr)
      6'd0: m_bus_out = mst_spcr;
      6'd1: m_bus_out = 8'(mst_spif) << SPSR_SPIF;
      6'd2: m_bus_out = mst_shreg;
      default: m_bus_out = 8'h00;
    endcase
  end

  // Client models: byte k of a burst is base + k.
  logic [7:0] base [NREQ];
  int txsnap [NREQ];
  int rxsnap [NREQ];
  int txcnt [NREQ];
  int rxcnt [NREQ];
  int done_cnt [NREQ];
  int ss_low [NREQ];
  int rx_bad = 0, viol = 0, spdr_wr = 0, cfg_wr = 0, gcnt = 0, since = 0, gap_min = 1000;
  bit have_done = 1'b0;
  logic [7:0] last_spdr = '0, last_cfg = '0;
  logic [NREQ-1:0] prev_gnt = '0;
  logic [NREQ-1:0] gseq [64];

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      base[i] = '0; txsnap[i] = 0; rxsnap[i] = 0; txcnt[i] = 0; rxcnt[i] = 0;
      done_cnt[i] = 0; ss_low[i] = 0;
    end
  end

  always_comb begin
    tx_data = '0;
    for (int i = 0; i < NREQ; i++) tx_data[i*8 +: 8] = 8'(int'(base[i]) + txcnt[i] - txsnap[i]);
  end

  always @(negedge clk) begin
    if (rst) begin
      have_done = 1'b0;
      prev_gnt  = '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (tx_ready[i]) txcnt[i] = txcnt[i] + 1;
        if (rx_valid[i]) begin
          if (rx_data !== 8'(int'(base[i]) + rxcnt[i] - rxsnap[i])) rx_bad = rx_bad + 1;
          rxcnt[i] = rxcnt[i] + 1;
        end
        if (done[i]) begin
          done_cnt[i] = done_cnt[i] + 1;
          if (ss_n[i] !== 1'b1) viol = viol + 1;
        end
        if (ss_n[i] === 1'b0) ss_low[i] = ss_low[i] + 1;
      end
      if (m_wr && m_rd) viol = viol + 1;
      if (m_wr && m_int) viol = viol + 1;
      if (m_wr && m_addr == 6'd2) begin
        spdr_wr   = spdr_wr + 1;
        last_spdr = m_bus_in;
        if (&ss_n) viol = viol + 1;
      end
      if (m_wr && m_addr == 6'd0) begin
        cfg_wr   = cfg_wr + 1;
        last_cfg = m_bus_in;
        if (have_done && since < gap_min) gap_min = since;
      end
      since = since + 1;
      if (|done) begin
        since     = 0;
        have_done = 1'b1;
      end
      if (gnt != '0 && prev_gnt == '0) begin
        gseq[gcnt % 64] = gnt;
        gcnt = gcnt + 1;
      end
      prev_gnt = gnt;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic start(input int idx, input logic [7:0] cfg, input logic [7:0] len, input logic [7:0] b);
    req_cfg[idx*8 +: 8]         = cfg;
    req_len[idx*LEN_W +: LEN_W] = len;
    base[idx]   = b;
    txsnap[idx] = txcnt[idx];
    rxsnap[idx] = rxcnt[idx];
    req[idx]    = 1'b1;
  endtask

  task automatic wait_gnt(input int idx, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick(1);
      if (gnt[idx]) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int idx, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      tick(1);
      if (done_cnt[idx] >= target) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    int d1;
    rst = 1'b1;
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
    checks++; if (ss_n !== 2'b11) begin errors++; $display("FAIL reset_ss_n got %b want 11", ss_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({m_wr, m_rd, m_int_rst} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {m_wr, m_rd, m_int_rst}); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    checks++; if ({done, tx_ready, rx_valid} !== 6'b0) begin errors++; $display("FAIL reset_pulses got %b want 000000", {done, tx_ready, rx_valid}); end
    tick(2);
    rst = 1'b0;
    tick(1);
    d1 = done_cnt[1];
    start(1, 8'h00, 8'd0, 8'h77);
    tick(1);
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL first_gnt_req1 got %b want 10", gnt); end
    checks++; if (ss_n !== 2'b01) begin errors++; $display("FAIL first_ss_n_req1 got %b want 01", ss_n); end
    req[1] = 1'b0;
    wait_done(1, d1 + 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL first_done_req1 got timeout want done"); end
    tick(3);
  endtask

  task automatic test_single();
    bit ok;
    int s_wr, s_cfg, s_low, s_d, s_tx, s_rx;
    s_wr = spdr_wr; s_cfg = cfg_wr; s_low = ss_low[0]; s_d = done_cnt[0]; s_tx = txcnt[0]; s_rx = rxcnt[0];
    start(0, 8'h01, 8'd0, 8'hA5);
    wait_gnt(0, ok);
    req[0] = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL single_gnt got timeout want gnt"); end
    wait_done(0, s_d + 1, 200, ok);
    tick(3);
    checks++; if (!ok) begin errors++; $display("FAIL single_done got timeout want done"); end
    checks++; if (spdr_wr - s_wr != 1) begin errors++; $display("FAIL single_spdr_writes got %0d want 1", spdr_wr - s_wr); end
    checks++; if (last_spdr !== 8'hA5) begin errors++; $display("FAIL single_spdr_data got %h want a5", last_spdr); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_data got %h want a5", rx_data); end
    checks++; if (rxcnt[0] - s_rx != 1) begin errors++; $display("FAIL single_rx_valid got %0d want 1", rxcnt[0] - s_rx); end
    checks++; if (txcnt[0] - s_tx != 1) begin errors++; $display("FAIL single_tx_ready got %0d want 1", txcnt[0] - s_tx); end
    checks++; if (done_cnt[0] - s_d != 1) begin errors++; $display("FAIL single_done_cycles got %0d want 1", done_cnt[0] - s_d); end
    checks++; if (ss_low[0] - s_low != 13) begin errors++; $display("FAIL single_ss_low_cycles got %0d want 13", ss_low[0] - s_low); end
    checks++; if (cfg_wr - s_cfg != 1) begin errors++; $display("FAIL single_cfg_writes got %0d want 1", cfg_wr - s_cfg); end
    checks++; if (last_cfg !== 8'hD1) begin errors++; $display("FAIL single_cfg_value got %h want d1", last_cfg); end
  endtask

  task automatic test_burst4();
    bit ok;
    int s_wr, s_cfg, s_d, s_tx, s_rx;
    s_wr = spdr_wr; s_cfg = cfg_wr; s_d = done_cnt[0]; s_tx = txcnt[0]; s_rx = rxcnt[0];
    start(0, 8'h25, 8'd3, 8'h01);
    wait_gnt(0, ok);
    req[0] = 1'b0;
    wait_done(0, s_d + 1, 400, ok);
    tick(3);
    checks++; if (!ok) begin errors++; $display("FAIL burst4_done got timeout want done"); end
    checks++; if (txcnt[0] - s_tx != 4) begin errors++; $display("FAIL burst4_tx_ready got %0d want 4", txcnt[0] - s_tx); end
    checks++; if (rxcnt[0] - s_rx != 4) begin errors++; $display("FAIL burst4_rx_valid got %0d want 4", rxcnt[0] - s_rx); end
    checks++; if (spdr_wr - s_wr != 4) begin errors++; $display("FAIL burst4_spdr_writes got %0d want 4", spdr_wr - s_wr); end
    checks++; if (last_spdr !== 8'h04) begin errors++; $display("FAIL burst4_last_tx got %h want 04", last_spdr); end
    checks++; if (rx_data !== 8'h04) begin errors++; $display("FAIL burst4_last_rx got %h want 04", rx_data); end
    checks++; if (cfg_wr - s_cfg != 1) begin errors++; $display("FAIL burst4_cfg_writes got %0d want 1", cfg_wr - s_cfg); end
    checks++; if (last_cfg !== 8'hF5) begin errors++; $display("FAIL burst4_cfg_value got %h want f5", last_cfg); end
    checks++; if (rx_bad != 0) begin errors++; $display("FAIL burst4_rx_order got %0d bad want 0", rx_bad); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int s_g, s_d0, s_d1;
    logic [NREQ-1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    do_reset();
    s_g = gcnt; s_d0 = done_cnt[0]; s_d1 = done_cnt[1];
    start(0, 8'h00, 8'd0, 8'h20);
    start(1, 8'h00, 8'd0, 8'h30);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      tick(1);
      if (gcnt - s_g >= 4) ok = 1'b1;
    end
    req = '0;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_grants got %0d want 4", gcnt - s_g); end
    wait_done(1, s_d1 + 2, 200, ok);
    tick(3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (gseq[(s_g + k) % 64] !== exp_g[k]) begin
        errors++; $display("FAIL b2b_grant_%0d got %b want %b", k, gseq[(s_g + k) % 64], exp_g[k]);
      end
    end
    checks++; if (done_cnt[0] - s_d0 != 2) begin errors++; $display("FAIL b2b_done0 got %0d want 2", done_cnt[0] - s_d0); end
    checks++; if (done_cnt[1] - s_d1 != 2) begin errors++; $display("FAIL b2b_done1 got %0d want 2", done_cnt[1] - s_d1); end
    checks++; if (gap_min < 1) begin errors++; $display("FAIL b2b_idle_gap got %0d want >=1", gap_min); end
    checks++; if (rx_bad != 0) begin errors++; $display("FAIL b2b_rx_order got %0d bad want 0", rx_bad); end
  endtask

  task automatic test_drop();
    bit ok;
    int s_d, s_rx, s_tx, s_g;
    s_d = done_cnt[1]; s_rx = rxcnt[1]; s_tx = txcnt[1]; s_g = gcnt;
    start(1, 8'h00, 8'd3, 8'h10);
    wait_gnt(1, ok);
    for (int c = 0; c < 100 && (txcnt[1] - s_tx < 2); c++) tick(1);
    req[1] = 1'b0;
    wait_done(1, s_d + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_done got timeout want done"); end
    tick(20);
    checks++; if (rxcnt[1] - s_rx != 4) begin errors++; $display("FAIL drop_rx_valid got %0d want 4", rxcnt[1] - s_rx); end
    checks++; if (done_cnt[1] - s_d != 1) begin errors++; $display("FAIL drop_done_count got %0d want 1", done_cnt[1] - s_d); end
    checks++; if (gcnt - s_g != 1) begin errors++; $display("FAIL drop_regrant got %0d grants want 1", gcnt - s_g); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b want 0", busy); end
  endtask

  task automatic test_rst_mid();
    bit ok;
    int s_tx, s_d, s_rx;
    s_tx = txcnt[0];
    start(0, 8'h00, 8'd3, 8'h40);
    wait_gnt(0, ok);
    for (int c = 0; c < 50 && (txcnt[0] - s_tx < 1); c++) tick(1);
    tick(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
    #2 rst = 1'b1;
    req[0] = 1'b0;
    #1;
    checks++; if (ss_n !== 2'b11) begin errors++; $display("FAIL rstmid_ss_n got %b want 11", ss_n); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rstmid_gnt got %b want 00", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    tick(2);
    rst = 1'b0;
    tick(1);
    s_d = done_cnt[1]; s_rx = rxcnt[1];
    start(1, 8'h00, 8'd0, 8'h3C);
    wait_gnt(1, ok);
    req[1] = 1'b0;
    wait_done(1, s_d + 1, 200, ok);
    tick(3);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_fresh_done got timeout want done"); end
    checks++; if (rxcnt[1] - s_rx != 1) begin errors++; $display("FAIL rstmid_fresh_rx got %0d want 1", rxcnt[1] - s_rx); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL rstmid_fresh_data got %h want 3c", rx_data); end
  endtask

  task automatic test_long();
    bit ok;
    int s_wr, s_d, s_tx, s_rx;
    s_wr = spdr_wr; s_d = done_cnt[0]; s_tx = txcnt[0]; s_rx = rxcnt[0];
    start(0, 8'h00, 8'd255, 8'h00);
    wait_gnt(0, ok);
    req[0] = 1'b0;
    wait_done(0, s_d + 1, 5000, ok);
    tick(20);
    checks++; if (!ok) begin errors++; $display("FAIL long_done got timeout want done"); end
    checks++; if (txcnt[0] - s_tx != 256) begin errors++; $display("FAIL long_tx_ready got %0d want 256", txcnt[0] - s_tx); end
    checks++; if (rxcnt[0] - s_rx != 256) begin errors++; $display("FAIL long_rx_valid got %0d want 256", rxcnt[0] - s_rx); end
    checks++; if (spdr_wr - s_wr != 256) begin errors++; $display("FAIL long_spdr_writes got %0d want 256", spdr_wr - s_wr); end
    checks++; if (done_cnt[0] - s_d != 1) begin errors++; $display("FAIL long_done_count got %0d want 1", done_cnt[0] - s_d); end
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL long_last_rx got %h want ff", rx_data); end
    checks++; if (rx_bad != 0) begin errors++; $display("FAIL long_rx_order got %0d bad want 0", rx_bad); end
  endtask

  task automatic test_protocol();
    checks++; if (viol != 0) begin errors++; $display("FAIL bus_protocol got %0d violations want 0", viol); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_burst4();
    test_back_to_back();
    test_drop();
    test_rst_mid();
    test_long();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
